// File: rtl/dvs_evt_pkg.sv
// Shared types and constants for the DVS event path.
//   P_NONE / P_ON / P_OFF : 2-bit polarity codes carried in dvs_event_t.p
//   COORD_W / TS_W        : widths of the x/y coordinate and timestamp fields
//   dvs_event_t           : packed address-event {x, y, t, p}
package dvs_evt_pkg;

    localparam int COORD_W = 2;
    localparam int TS_W    = 2;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_ON   = 2'b01;
    localparam logic [1:0] P_OFF  = 2'b10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [TS_W-1:0]    t;
        logic [1:0]         p;
    } dvs_event_t;

endpackage

// File: rtl/dvs_evt_fifo.sv
// Small synchronous FIFO of dvs_event_t used to buffer events between the
// comparator stage and the output hold register.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; a push on a full FIFO is only
//                taken when a pop happens in the same cycle
//   pop        : read request, ignored when empty
//   dout       : current head entry (valid whenever empty=0)
//   full/empty : occupancy flags
module dvs_evt_fifo
    import dvs_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  dvs_event_t din,
    input  logic       pop,
    output dvs_event_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    dvs_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: no reset needed, entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dvs_event_encoder.sv
// DVS event encoder: compares per-pixel intensity samples of a 4x4 array
// against a stored reference and emits ON/OFF address-events {x,y,t,p}
// through a FIFO and a minimum-hold valid/ready output register.
//   clk, rst_n            : clock, synchronous active-low reset
//   pix_valid/x/y/val     : incoming sample, at most one per cycle
//   x_out/y_out/t_out/p_out, ev_valid, ev_ready : held event output
//   overflow              : sticky flag, an event was lost on a full FIFO
// Build option: define DVS_REFRACTORY_EN to add a per-pixel dead time of
// REFRACT_CYC cycles after each emitted event.
module dvs_event_encoder
    import dvs_evt_pkg::*;
#(
    parameter int INT_W      = 8,
    parameter int THRESH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_DIV     = 4,
    parameter int MIN_HOLD   = 6
`ifdef DVS_REFRACTORY_EN
    ,
    parameter int REFRACT_CYC = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [1:0]       pix_x,
    input  logic [1:0]       pix_y,
    input  logic [INT_W-1:0] pix_val,
    output logic [1:0]       x_out,
    output logic [1:0]       y_out,
    output logic [1:0]       t_out,
    output logic [1:0]       p_out,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             overflow
);

    localparam int NPIX    = 16;
    localparam int PRESC_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic signed [INT_W:0] THR = (INT_W+1)'(THRESH);

    logic [PRESC_W-1:0] presc;
    logic [TS_W-1:0]    ts;

    logic [INT_W-1:0]   ref_q [NPIX];
    logic [NPIX-1:0]    init_q;
    logic [3:0]         idx;
    logic signed [INT_W:0] diff;
    logic               blocked;
    logic               fire_on;
    logic               fire_off;
    logic               fire;
    logic [1:0]         pol;

    logic               s1_valid;
    dvs_event_t         s1_ev;

    dvs_event_t         head;
    logic               fifo_full;
    logic               fifo_empty;

    dvs_event_t         out_ev;
    logic               out_valid;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               accept;
    logic               load;
    logic               overflow_q;

    assign idx = {pix_y, pix_x};

    // Timestamp generator: the prescaler divides clk by TS_DIV and the
    // 2-bit stamp advances once per prescaler wrap, wrapping 3 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            ts    <= '0;
        end else if (presc == PRESC_W'(TS_DIV - 1)) begin
            presc <= '0;
            ts    <= ts + TS_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

`ifdef DVS_REFRACTORY_EN
    localparam int RC_W = $clog2(REFRACT_CYC + 1);
    logic [RC_W-1:0] refr_q [NPIX];

    assign blocked = (refr_q[idx] != '0);

    // Per-pixel dead-time counters: reloaded whenever the pixel emits an
    // event (even if the FIFO later drops it) and otherwise count to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                refr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                if (fire && (idx == 4'(i))) begin
                    refr_q[i] <= RC_W'(REFRACT_CYC);
                end else if (refr_q[i] != '0) begin
                    refr_q[i] <= refr_q[i] - RC_W'(1);
                end
            end
        end
    end
`else
    assign blocked = 1'b0;
`endif

    // Contrast comparator: signed difference one bit wider than the
    // samples so that both directions are representable without overflow.
    always_comb begin
        diff     = $signed({1'b0, pix_val}) - $signed({1'b0, ref_q[idx]});
        fire_on  = pix_valid & init_q[idx] & ~blocked & (diff >= THR);
        fire_off = pix_valid & init_q[idx] & ~blocked & (diff <= -THR);
        fire     = fire_on | fire_off;
        pol      = P_NONE;
        if (fire_on) begin
            pol = P_ON;
        end else if (fire_off) begin
            pol = P_OFF;
        end
    end

    // Reference memory and stage-1 event register. The first sample of a
    // pixel only seeds its reference; later samples move the reference
    // only when they produce an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q   <= '0;
            s1_valid <= 1'b0;
            s1_ev    <= '0;
            for (int i = 0; i < NPIX; i++) begin
                ref_q[i] <= '0;
            end
        end else begin
            s1_valid <= fire;
            s1_ev    <= '{x: pix_x, y: pix_y, t: ts, p: pol};
            if (pix_valid && !init_q[idx]) begin
                init_q[idx] <= 1'b1;
                ref_q[idx]  <= pix_val;
            end else if (fire) begin
                ref_q[idx]  <= pix_val;
            end
        end
    end

    dvs_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_valid),
        .din   (s1_ev),
        .pop   (load),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign accept = out_valid & ev_ready & (hold_cnt == HOLD_W'(MIN_HOLD - 1));
    // Refill on the accepting edge itself so back-to-back events keep
    // ev_valid high without a bubble.
    assign load   = ~fifo_empty & (~out_valid | accept);

    // Output hold register: an event is held for at least MIN_HOLD cycles
    // before ev_ready is honoured, and the fields read as zero when empty.
    // The overflow flag latches whenever stage 1 finds the FIFO full and
    // nothing leaves it in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ev     <= '0;
            hold_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (s1_valid && fifo_full && !load) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_ev    <= head;
                hold_cnt  <= '0;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_ev    <= '0;
            end else if (out_valid && (hold_cnt != HOLD_W'(MIN_HOLD - 1))) begin
                hold_cnt  <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign x_out    = out_ev.x;
    assign y_out    = out_ev.y;
    assign t_out    = out_ev.t;
    assign p_out    = out_ev.p;
    assign ev_valid = out_valid;
    assign overflow = overflow_q;

endmodule
